// File: rtl/posit_pipe_shifter_if.sv
// posit_pipe_shifter_if
// Handshake bundle for the pipelined posit barrel shifter.
//   in_valid/in_ready   : input beat handshake (in_ready driven by the shifter)
//   in_data/in_shamt    : operand and unsigned shift amount
//   in_dir              : 0 = right shift, 1 = left shift
//   in_arith            : right shifts only, 1 = sign fill
//   out_valid/out_ready : result handshake (out_ready driven by the consumer)
//   out_data/out_sticky : shifted word and OR of every discarded operand bit
// The WORD_SIZE/RS parameters must match those of the attached shifter.
interface posit_pipe_shifter_if #(
  parameter int WORD_SIZE = 32,
  parameter int RS        = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic [RS-1:0]        in_shamt;
  logic                 in_dir;
  logic                 in_arith;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;
  logic                 out_sticky;

  modport master (
    output in_valid, in_data, in_shamt, in_dir, in_arith, out_ready,
    input  in_ready, out_valid, out_data, out_sticky
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_dir, in_arith, out_ready,
    output in_ready, out_valid, out_data, out_sticky
  );
endinterface

// File: rtl/posit_pipe_shifter.sv
// posit_pipe_shifter
// Pipelined barrel shifter (logical/arithmetic right, logical left) with a
// sticky output for downstream rounding. Shift level i (shift by 2^i) is
// evaluated in stage floor(i*STAGES/RS); each stage ends in a register, so the
// latency is STAGES cycles. One global enable freezes the whole pipeline when
// the output is held by the consumer.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset (clears all valid bits)
//   bus       : posit_pipe_shifter_if.slave (input beat in, shifted result out)
module posit_pipe_shifter #(
  parameter int WORD_SIZE = 32,
  parameter int RS        = 5,
  parameter int STAGES    = 2
) (
  input logic                 clk,
  input logic                 rst,
  posit_pipe_shifter_if.slave bus
);

  // Everything a stage needs to finish the shift. The full shift amount is
  // carried so a level can tell how many fill bits earlier levels inserted.
  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    logic                 sticky;
    logic                 dir;
    logic                 arith;
    logic                 sign;
    logic [RS-1:0]        shamt;
  } beat_t;

  function automatic int level_stage(input int lvl);
    return (lvl * STAGES) / RS;
  endfunction

  // One shift level by 2^lvl, folding the discarded operand bits into sticky.
  // For an arithmetic right shift the top bits may already be sign fill from
  // lower levels; those are masked out so only original operand bits count.
  function automatic beat_t apply_level(input beat_t b, input int lvl);
    beat_t                r;
    logic [WORD_SIZE-1:0] ones;
    logic [WORD_SIZE-1:0] orig;
    logic [WORD_SIZE-1:0] discard;
    logic                 fill;
    int                   amt;
    int                   done;
    r       = b;
    ones    = '1;
    amt     = 1 << lvl;
    done    = int'(b.shamt) & (amt - 1);
    fill    = b.arith & b.sign & ~b.dir;
    orig    = ones;
    if (b.dir) begin
      discard = ~(ones >> amt);
      r.data  = b.data << amt;
    end else begin
      if (fill) orig = ones >> done;
      discard = ~(ones << amt) & orig;
      r.data  = (b.data >> amt) | (fill ? ~(ones >> amt) : '0);
    end
    r.sticky = b.sticky | (|(b.data & discard));
    return r;
  endfunction

  beat_t in_beat;
  beat_t beat_nxt [STAGES];
  beat_t beat_p   [STAGES];
  logic  vld_p    [STAGES];
  logic  en;

  assign en = bus.out_ready | ~vld_p[STAGES-1];

  assign in_beat.data   = bus.in_data;
  assign in_beat.sticky = 1'b0;
  assign in_beat.dir    = bus.in_dir;
  assign in_beat.arith  = bus.in_arith;
  assign in_beat.sign   = bus.in_data[WORD_SIZE-1];
  assign in_beat.shamt  = bus.in_shamt;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    beat_t src;
    beat_t nxt;

    // Stage s input: the interface for stage 0, else the previous register
    if (s == 0) begin : g_head
      assign src = in_beat;
    end else begin : g_tail
      assign src = beat_p[s-1];
    end

    always_comb begin
      nxt = src;
      for (int i = 0; i < RS; i++) begin
        if (level_stage(i) == s && nxt.shamt[i]) nxt = apply_level(nxt, i);
      end
    end

    assign beat_nxt[s] = nxt;
  end

  // Stage registers: valid bits carry the reset, data simply follows en
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) vld_p[s] <= 1'b0;
    end else if (en) begin
      vld_p[0] <= bus.in_valid;
      for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int s = 0; s < STAGES; s++) beat_p[s] <= beat_nxt[s];
    end
  end

  // Output: gated by valid so an empty pipeline presents zero
  assign bus.in_ready   = en;
  assign bus.out_valid  = vld_p[STAGES-1];
  assign bus.out_data   = vld_p[STAGES-1] ? beat_p[STAGES-1].data : '0;
  assign bus.out_sticky = vld_p[STAGES-1] & beat_p[STAGES-1].sticky;

endmodule

// File: tb/tb_posit_pipe_shifter.sv
// tb_posit_pipe_shifter
// Self-checking bench for posit_pipe_shifter: a 32-bit/STAGES=2 main instance
// with full handshake control, three 32-bit instances (STAGES 1, 3, 5) fed a
// shared stream, and a 16-bit/STAGES=3 instance with over-range shifts.
module tb_posit_pipe_shifter;

  localparam int SWEEP_N = 40;
  localparam int W16_N   = 30;
  localparam int SW_ST [3] = '{1, 3, 5};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Main instance
  posit_pipe_shifter_if #(.WORD_SIZE(32), .RS(5)) m_if ();
  posit_pipe_shifter #(.WORD_SIZE(32), .RS(5), .STAGES(2)) u_main (
    .clk(clk), .rst(rst), .bus(m_if.slave));

  // Sweep instances sharing one input stream, always ready at the output
  logic        sw_valid;
  logic [31:0] sw_data;
  logic [4:0]  sw_shamt;
  logic        sw_dir;
  logic        sw_arith;
  logic        sw_ov [3];
  logic [31:0] sw_od [3];
  logic        sw_os [3];

  for (genvar g = 0; g < 3; g++) begin : g_sw
    posit_pipe_shifter_if #(.WORD_SIZE(32), .RS(5)) sif ();
    assign sif.in_valid  = sw_valid;
    assign sif.in_data   = sw_data;
    assign sif.in_shamt  = sw_shamt;
    assign sif.in_dir    = sw_dir;
    assign sif.in_arith  = sw_arith;
    assign sif.out_ready = 1'b1;
    assign sw_ov[g] = sif.out_valid;
    assign sw_od[g] = sif.out_data;
    assign sw_os[g] = sif.out_sticky;
    posit_pipe_shifter #(.WORD_SIZE(32), .RS(5), .STAGES(SW_ST[g])) u_sw (
      .clk(clk), .rst(rst), .bus(sif.slave));
  end

  // 16-bit instance
  posit_pipe_shifter_if #(.WORD_SIZE(16), .RS(5)) h_if ();
  posit_pipe_shifter #(.WORD_SIZE(16), .RS(5), .STAGES(3)) u_w16 (
    .clk(clk), .rst(rst), .bus(h_if.slave));

  // Reference: value-level shift of a w-bit word, sticky = any operand bit lost
  function automatic void ref_shift(input int w, input logic [31:0] d, input int sh,
                                    input bit dir, input bit ar,
                                    output logic [31:0] r, output bit st);
    longint unsigned mask;
    longint unsigned x;
    longint          sx;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    if (sh == 0) begin
      r  = x[31:0];
      st = 1'b0;
    end else if (!dir) begin
      if (ar && x[w-1]) sx = longint'(x) - longint'(64'd1 << w);
      else              sx = longint'(x);
      if (sh >= w) begin
        r  = (sx < 0) ? mask[31:0] : 32'd0;
        st = (x != 0);
      end else begin
        r  = 32'((sx >>> sh) & longint'(mask));
        st = ((x & ((64'd1 << sh) - 64'd1)) != 0);
      end
    end else begin
      if (sh >= w) begin
        r  = 32'd0;
        st = (x != 0);
      end else begin
        r  = 32'((x << sh) & mask);
        st = ((x >> (w - sh)) != 0);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_main_beat();
    m_if.in_data  = $urandom;
    m_if.in_shamt = 5'($urandom_range(0, 31));
    m_if.in_dir   = 1'($urandom_range(0, 1));
    m_if.in_arith = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_if.in_valid = 1'b0;
    m_if.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (m_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", m_if.out_valid); end
    n_vec++; if (m_if.out_data !== 32'd0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 0", m_if.out_data); end
    n_vec++; if (m_if.out_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_out_sticky: got %b expected 0", m_if.out_sticky); end
    n_vec++; if (m_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", m_if.in_ready); end
  endtask

  // One isolated beat with spec-given expectations; checks the latency too
  task automatic test_directed(input string name, input logic [31:0] d, input int sh,
                               input bit dir, input bit ar,
                               input logic [31:0] exp_d, input bit exp_s);
    m_if.in_data   = d;
    m_if.in_shamt  = 5'(sh);
    m_if.in_dir    = dir;
    m_if.in_arith  = ar;
    m_if.in_valid  = 1'b1;
    m_if.out_ready = 1'b1;
    #1;
    n_vec++; if (m_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_in_ready: got %b expected 1", name, m_if.in_ready); end
    tick();
    m_if.in_valid = 1'b0;
    n_vec++; if (m_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_early_valid: got %b expected 0", name, m_if.out_valid); end
    tick();
    n_vec++; if (m_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid: got %b expected 1", name, m_if.out_valid); end
    n_vec++; if (m_if.out_data !== exp_d || m_if.out_sticky !== exp_s) begin
      n_bad++; $display("FAIL %s_result: got %h/%b expected %h/%b", name, m_if.out_data, m_if.out_sticky, exp_d, exp_s);
    end
    tick();
    n_vec++; if (m_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_dup: got valid %b expected 0", name, m_if.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qd[$];
    bit          qs[$];
    logic [31:0] r;
    bit          s;
    logic [31:0] held_d;
    bit          held_s;
    bit          xfer;
    bit          hold_done = 1'b0;
    int          hold_left = 0;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    m_if.in_valid = 1'b0;
    while (got < 8 && cyc < 200) begin
      if (!m_if.in_valid && sent < 8) begin
        rand_main_beat();
        m_if.in_valid = 1'b1;
      end
      if (!hold_done && got == 2) begin
        hold_left = 3;
        hold_done = 1'b1;
      end
      m_if.out_ready = (hold_left == 0);
      #1;
      if (hold_left > 0) begin
        n_vec++; if (m_if.in_ready !== 1'b0 || m_if.out_valid !== 1'b1) begin
          n_bad++; $display("FAIL b2b_hold: got in_ready %b out_valid %b expected 0/1", m_if.in_ready, m_if.out_valid);
        end
        if (hold_left == 3) begin
          held_d = m_if.out_data;
          held_s = m_if.out_sticky;
        end else begin
          n_vec++; if (m_if.out_data !== held_d || m_if.out_sticky !== held_s) begin
            n_bad++; $display("FAIL b2b_stable: got %h/%b expected %h/%b", m_if.out_data, m_if.out_sticky, held_d, held_s);
          end
        end
        hold_left--;
      end
      if (m_if.out_valid && m_if.out_ready) begin
        n_vec++;
        if (qd.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra: got %h with no beat outstanding expected none", m_if.out_data);
        end else begin
          if (m_if.out_data !== qd[0] || m_if.out_sticky !== qs[0]) begin
            n_bad++; $display("FAIL b2b_result: got %h/%b expected %h/%b", m_if.out_data, m_if.out_sticky, qd[0], qs[0]);
          end
          void'(qd.pop_front());
          void'(qs.pop_front());
          got++;
        end
      end
      xfer = m_if.in_valid && m_if.in_ready;
      if (xfer) begin
        ref_shift(32, m_if.in_data, int'(m_if.in_shamt), m_if.in_dir, m_if.in_arith, r, s);
        qd.push_back(r);
        qs.push_back(s);
        sent++;
      end
      tick();
      if (xfer) m_if.in_valid = 1'b0;
      cyc++;
    end
    m_if.in_valid = 1'b0;
    m_if.out_ready = 1'b1;
    n_vec++; if (got != 8 || qd.size() != 0 || !hold_done) begin
      n_bad++; $display("FAIL b2b_count: got %0d results (%0d pending) expected 8 (0)", got, qd.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] qd[$];
    bit          qs[$];
    logic [31:0] r;
    bit          s;
    bit          xfer;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    m_if.in_valid = 1'b0;
    while (got < 60 && cyc < 2000) begin
      if (!m_if.in_valid && sent < 60 && $urandom_range(0, 3) != 0) begin
        rand_main_beat();
        m_if.in_valid = 1'b1;
      end
      m_if.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (m_if.out_valid && m_if.out_ready) begin
        n_vec++;
        if (qd.size() == 0) begin
          n_bad++; $display("FAIL rand_extra: got %h with no beat outstanding expected none", m_if.out_data);
        end else begin
          if (m_if.out_data !== qd[0] || m_if.out_sticky !== qs[0]) begin
            n_bad++; $display("FAIL rand_result: got %h/%b expected %h/%b", m_if.out_data, m_if.out_sticky, qd[0], qs[0]);
          end
          void'(qd.pop_front());
          void'(qs.pop_front());
          got++;
        end
      end
      xfer = m_if.in_valid && m_if.in_ready;
      if (xfer) begin
        ref_shift(32, m_if.in_data, int'(m_if.in_shamt), m_if.in_dir, m_if.in_arith, r, s);
        qd.push_back(r);
        qs.push_back(s);
        sent++;
      end
      tick();
      if (xfer) m_if.in_valid = 1'b0;
      cyc++;
    end
    m_if.in_valid = 1'b0;
    m_if.out_ready = 1'b1;
    n_vec++; if (got != 60 || qd.size() != 0) begin
      n_bad++; $display("FAIL rand_count: got %0d results (%0d pending) expected 60 (0)", got, qd.size());
    end
  endtask

  task automatic test_reset_midstream();
    m_if.out_ready = 1'b1;
    m_if.in_valid  = 1'b1;
    m_if.in_data   = 32'hDEAD_BEEF;
    m_if.in_shamt  = 5'd1;
    m_if.in_dir    = 1'b0;
    m_if.in_arith  = 1'b0;
    tick();
    m_if.in_data = 32'h1234_5678;
    tick();
    m_if.in_valid  = 1'b0;
    m_if.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (m_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b expected 0", m_if.out_valid); end
    n_vec++; if (m_if.out_data !== 32'd0) begin n_bad++; $display("FAIL midrst_data: got %h expected 0", m_if.out_data); end
    n_vec++; if (m_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b expected 1", m_if.in_ready); end
    m_if.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++; if (m_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_ghost: got valid %b data %h expected 0", m_if.out_valid, m_if.out_data); end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] bd [SWEEP_N];
    logic [31:0] er [SWEEP_N];
    int          bsh [SWEEP_N];
    bit          bv [SWEEP_N];
    bit          bdir [SWEEP_N];
    bit          bar [SWEEP_N];
    bit          es [SWEEP_N];
    bit          exp_v;
    int          k;
    for (int i = 0; i < SWEEP_N; i++) begin
      bv[i]   = ($urandom_range(0, 4) != 0);
      bd[i]   = $urandom;
      bsh[i]  = $urandom_range(0, 31);
      bdir[i] = 1'($urandom_range(0, 1));
      bar[i]  = 1'($urandom_range(0, 1));
      ref_shift(32, bd[i], bsh[i], bdir[i], bar[i], er[i], es[i]);
    end
    sw_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < SWEEP_N + 6; j++) begin
      for (int g = 0; g < 3; g++) begin
        k = j - SW_ST[g];
        exp_v = 1'b0;
        if (k >= 0 && k < SWEEP_N) exp_v = bv[k];
        n_vec++; if (sw_ov[g] !== exp_v) begin
          n_bad++; $display("FAIL sweep_s%0d_valid: cycle %0d got %b expected %b", SW_ST[g], j, sw_ov[g], exp_v);
        end
        if (exp_v) begin
          n_vec++; if (sw_od[g] !== er[k] || sw_os[g] !== es[k]) begin
            n_bad++; $display("FAIL sweep_s%0d_result: beat %0d got %h/%b expected %h/%b", SW_ST[g], k, sw_od[g], sw_os[g], er[k], es[k]);
          end
        end
      end
      if (j < SWEEP_N) begin
        sw_valid = bv[j];
        sw_data  = bd[j];
        sw_shamt = 5'(bsh[j]);
        sw_dir   = bdir[j];
        sw_arith = bar[j];
      end else begin
        sw_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_w16();
    logic [15:0] bd [W16_N];
    logic [31:0] er [W16_N];
    int          bsh [W16_N];
    bit          bv [W16_N];
    bit          bdir [W16_N];
    bit          bar [W16_N];
    bit          es [W16_N];
    bit          exp_v;
    int          k;
    for (int i = 0; i < W16_N; i++) begin
      bv[i]   = ($urandom_range(0, 4) != 0);
      bd[i]   = 16'($urandom);
      bsh[i]  = $urandom_range(0, 31);
      bdir[i] = 1'($urandom_range(0, 1));
      bar[i]  = 1'($urandom_range(0, 1));
    end
    bv[0] = 1'b1; bd[0] = 16'h8001; bsh[0] = 20; bdir[0] = 1'b0; bar[0] = 1'b1;
    for (int i = 0; i < W16_N; i++) ref_shift(16, {16'd0, bd[i]}, bsh[i], bdir[i], bar[i], er[i], es[i]);
    h_if.in_valid = 1'b0;
    h_if.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < W16_N + 5; j++) begin
      k = j - 3;
      exp_v = 1'b0;
      if (k >= 0 && k < W16_N) exp_v = bv[k];
      n_vec++; if (h_if.out_valid !== exp_v) begin
        n_bad++; $display("FAIL w16_valid: cycle %0d got %b expected %b", j, h_if.out_valid, exp_v);
      end
      if (exp_v) begin
        n_vec++; if (h_if.out_data !== er[k][15:0] || h_if.out_sticky !== es[k]) begin
          n_bad++; $display("FAIL w16_result: beat %0d got %h/%b expected %h/%b", k, h_if.out_data, h_if.out_sticky, er[k][15:0], es[k]);
        end
        if (k == 0) begin
          n_vec++; if (h_if.out_data !== 16'hFFFF || h_if.out_sticky !== 1'b1) begin
            n_bad++; $display("FAIL w16_overrange: got %h/%b expected ffff/1", h_if.out_data, h_if.out_sticky);
          end
        end
      end
      if (j < W16_N) begin
        h_if.in_valid = bv[j];
        h_if.in_data  = bd[j];
        h_if.in_shamt = 5'(bsh[j]);
        h_if.in_dir   = bdir[j];
        h_if.in_arith = bar[j];
      end else begin
        h_if.in_valid = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    m_if.in_valid = 1'b0; m_if.in_data = '0; m_if.in_shamt = '0;
    m_if.in_dir = 1'b0; m_if.in_arith = 1'b0; m_if.out_ready = 1'b1;
    sw_valid = 1'b0; sw_data = '0; sw_shamt = '0; sw_dir = 1'b0; sw_arith = 1'b0;
    h_if.in_valid = 1'b0; h_if.in_data = '0; h_if.in_shamt = '0;
    h_if.in_dir = 1'b0; h_if.in_arith = 1'b0; h_if.out_ready = 1'b1;
    #1;
    test_reset();
    test_directed("lsr",      32'h0000_00FF, 4, 1'b0, 1'b0, 32'h0000_000F, 1'b1);
    test_directed("asr",      32'h8000_0000, 4, 1'b0, 1'b1, 32'hF800_0000, 1'b0);
    test_directed("asr_off",  32'h8000_0000, 4, 1'b0, 1'b0, 32'h0800_0000, 1'b0);
    test_directed("lsl",      32'hF000_0001, 4, 1'b1, 1'b0, 32'h0000_0010, 1'b1);
    test_directed("lsl_arith",32'h8000_0001, 1, 1'b1, 1'b1, 32'h0000_0002, 1'b1);
    test_directed("pass",     32'h1234_ABCD, 0, 1'b0, 1'b1, 32'h1234_ABCD, 1'b0);
    test_back_to_back();
    test_random();
    test_reset_midstream();
    test_sweep();
    test_w16();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
